// File: rtl/pwm_fader.sv
// pwm_fader: walks a PWM duty register one LSB at a time toward a commanded
// target, changing duty only at period boundaries. Supports one-shot ramps
// and a continuous breathe mode that bounces between 0 and the target.
module pwm_fader #(
  parameter int dutyBits = 8,
  parameter int rateBits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [dutyBits-1:0] cmd_target,
  input  logic [rateBits-1:0] cmd_rate,
  input  logic                cmd_breathe,
  output logic [dutyBits-1:0] duty,
  output logic                busy,
  output logic                done,
  output logic                period_tick
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RAMP    = 2'd1;
  localparam logic [1:0] BREATHE = 2'd2;

  logic [1:0]          state;
  logic [dutyBits-1:0] pcnt;
  logic [dutyBits-1:0] target;
  logic [rateBits-1:0] rate;
  logic [rateBits-1:0] rcnt;
  logic                dir_up;
  logic                accept;
  logic                step_now;
  logic [dutyBits-1:0] next_duty;
  logic                next_dir_up;

  assign period_tick = (pcnt == '1);
  assign cmd_ready   = (state == IDLE) || (state == BREATHE);
  assign busy        = (state != IDLE);
  assign accept      = cmd_valid && cmd_ready;
  // Rate 0 means "jump", so every tick is a step; otherwise step once rcnt
  // has counted rate-1 earlier ticks.
  assign step_now    = (rate == '0) || (rcnt == (rate - rateBits'(1)));

  // Work out the duty value and direction a step would produce this tick.
  always_comb begin
    next_duty   = duty;
    next_dir_up = dir_up;
    if (state == RAMP) begin
      if (rate == '0)
        next_duty = target;
      else if (duty < target)
        next_duty = duty + dutyBits'(1);
      else if (duty > target)
        next_duty = duty - dutyBits'(1);
    end else if (state == BREATHE) begin
      if (rate == '0) begin
        // Jump mode breathe just flips between the peak and zero.
        next_duty   = dir_up ? target : '0;
        next_dir_up = !dir_up;
      end else if (target == '0) begin
        // Peak of zero: drain whatever duty is left, then sit at zero.
        next_duty   = (duty == '0) ? '0 : duty - dutyBits'(1);
        next_dir_up = 1'b1;
      end else begin
        // Climb only while below the peak; the floor forces a climb too.
        if ((dir_up && (duty < target)) || (duty == '0))
          next_duty = duty + dutyBits'(1);
        else
          next_duty = duty - dutyBits'(1);
        if (next_duty >= target)
          next_dir_up = 1'b0;
        else if (next_duty == '0)
          next_dir_up = 1'b1;
        else
          next_dir_up = (next_duty > duty);
      end
    end
  end

  // Period counter, command latch and tick-aligned duty sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      duty   <= '0;
      state  <= IDLE;
      done   <= 1'b0;
      target <= '0;
      rate   <= '0;
      rcnt   <= '0;
      dir_up <= 1'b1;
    end else begin
      pcnt <= pcnt + dutyBits'(1);
      done <= 1'b0;
      if (accept) begin
        // A tick coinciding with acceptance is deliberately not counted.
        target <= cmd_target;
        rate   <= cmd_rate;
        rcnt   <= '0;
        state  <= cmd_breathe ? BREATHE : RAMP;
        if (cmd_breathe) begin
          if (state == IDLE)
            dir_up <= 1'b1;
          else if (cmd_target < duty)
            dir_up <= 1'b0;
        end
      end else if (period_tick && (state != IDLE)) begin
        if ((state == RAMP) && (duty == target)) begin
          state <= IDLE;
          done  <= 1'b1;
        end else if (step_now) begin
          rcnt   <= '0;
          duty   <= next_duty;
          dir_up <= next_dir_up;
          if ((state == RAMP) && (next_duty == target)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end else begin
          rcnt <= rcnt + rateBits'(1);
        end
      end
    end
  end

endmodule
